// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT datapath: word sizes and a complex-word type.
// Also holds real/imag pack/unpack helpers that work for any half width up to MAX_HALF.
package fft_pkg;

  localparam int WORD_SZ_DEF = 16;
  localparam int MAX_HALF    = 32;

  function automatic int half_of(input int word_sz);
    return word_sz / 2;
  endfunction

  localparam int HALF_DEF = half_of(WORD_SZ_DEF);

  typedef struct packed {
    logic [HALF_DEF-1:0] re;
    logic [HALF_DEF-1:0] im;
  } cplx_t;

  typedef logic [2*MAX_HALF-1:0]      cword_max_t;
  typedef logic signed [MAX_HALF-1:0] half_max_t;

  // Callers zero-extend their word into cword_max_t; the half is sign-extended back out.
  function automatic half_max_t cplx_re(input cword_max_t w, input int half);
    half_max_t h;
    h = half_max_t'(w >> half);
    h = h <<< (MAX_HALF - half);
    return h >>> (MAX_HALF - half);
  endfunction

  function automatic half_max_t cplx_im(input cword_max_t w, input int half);
    half_max_t h;
    h = half_max_t'(w);
    h = h <<< (MAX_HALF - half);
    return h >>> (MAX_HALF - half);
  endfunction

  function automatic cword_max_t cplx_pack(input half_max_t re, input half_max_t im,
                                           input int half);
    cword_max_t mask;
    cword_max_t r;
    mask = (cword_max_t'(1) << half) - cword_max_t'(1);
    r    = ((cword_max_t'(re) & mask) << half) | (cword_max_t'(im) & mask);
    return r;
  endfunction

endpackage

// File: rtl/cmplx_mult.sv
// Complex multiply B*W with a Q1.(HALF-1) twiddle, rounded half-up back to HALF+2 bits.
// Output is registered and only updates when i_en is high.
module cmplx_mult
  import fft_pkg::*;
#(
  parameter int WORD_SZ = WORD_SZ_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_en,
  input  logic [WORD_SZ-1:0]     i_b,
  input  logic [WORD_SZ-1:0]     i_w,
  output logic [WORD_SZ/2+1:0]   o_pr,
  output logic [WORD_SZ/2+1:0]   o_pi
);

  localparam int HALF = half_of(WORD_SZ);
  localparam int FW   = 2 * HALF + 1;
  localparam int PW   = HALF + 2;
  localparam logic signed [FW-1:0] RND = FW'(2 ** (HALF - 2));

  logic signed [FW-1:0] br, bi, wr, wi;
  logic signed [FW-1:0] pr_full, pi_full;

  // Full-precision products never exceed 2^(2*HALF-1), so FW bits hold them exactly.
  always_comb begin
    br      = FW'(cplx_re(cword_max_t'(i_b), HALF));
    bi      = FW'(cplx_im(cword_max_t'(i_b), HALF));
    wr      = FW'(cplx_re(cword_max_t'(i_w), HALF));
    wi      = FW'(cplx_im(cword_max_t'(i_w), HALF));
    pr_full = br * wr - bi * wi + RND;
    pi_full = br * wi + bi * wr + RND;
  end

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      o_pr <= PW'(pr_full >>> (HALF - 1));
      o_pi <= PW'(pi_full >>> (HALF - 1));
    end
  end

endmodule

// File: rtl/butterfly_r2_pipe.sv
// Three-stage radix-2 DIT butterfly: S1 operand register, S2 complex multiply, S3 add/sub/scale/limit.
// Define BFLY_SAT_EN to saturate out-of-range result halves; otherwise they wrap.
module butterfly_r2_pipe
  import fft_pkg::*;
#(
  parameter int WORD_SZ = WORD_SZ_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [WORD_SZ-1:0] i_A,
  input  logic [WORD_SZ-1:0] i_B,
  input  logic [WORD_SZ-1:0] i_W,
  input  logic               i_scale,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [WORD_SZ-1:0] o_A,
  output logic [WORD_SZ-1:0] o_B,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_ovf,
  input  logic               i_clr_ovf
);

  localparam int HALF = half_of(WORD_SZ);
  localparam int PW   = HALF + 2;
  localparam int SW   = HALF + 3;

  if ((WORD_SZ % 2) != 0 || WORD_SZ < 8) begin : g_bad_word_sz
    $error("butterfly_r2_pipe: WORD_SZ must be even and >= 8");
  end

  logic               s1_valid, s1_scale;
  logic [WORD_SZ-1:0] s1_a, s1_b, s1_w;
  logic               s2_valid, s2_scale;
  logic [WORD_SZ-1:0] s2_a;
  logic [PW-1:0]      s2_pr, s2_pi;
  logic               stall, adv;

  // Handshake: a beat enters when i_valid & o_ready, a result leaves when o_valid & i_ready.
  // Only a blocked output stalls; then every stage holds, otherwise all stages advance (bubbles too).
  assign stall   = o_valid & ~i_ready;
  assign adv     = ~stall;
  assign o_ready = adv;

  cmplx_mult #(
    .WORD_SZ(WORD_SZ)
  ) u_mult (
    .i_clk (i_clk),
    .i_en  (adv),
    .i_b   (s1_b),
    .i_w   (s1_w),
    .o_pr  (s2_pr),
    .o_pi  (s2_pi)
  );

  // Returns {out_of_range, limited value}.
  function automatic logic [HALF:0] limit_half(input logic signed [SW-1:0] v);
    logic            oor;
    logic [HALF-1:0] r;
    oor = (v[SW-1:HALF-1] != {(SW-HALF+1){v[HALF-1]}});
`ifdef BFLY_SAT_EN
    if (oor) r = v[SW-1] ? {1'b1, {(HALF-1){1'b0}}} : {1'b0, {(HALF-1){1'b1}}};
    else     r = v[HALF-1:0];
`else
    r = v[HALF-1:0];
`endif
    return {oor, r};
  endfunction

  logic signed [SW-1:0] a_re, a_im, p_re, p_im;
  logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;
  logic [HALF:0]        lim_sr, lim_si, lim_dr, lim_di;
  logic                 ovf_evt;
  logic [WORD_SZ-1:0]   res_a, res_b;

  always_comb begin
    a_re   = SW'(cplx_re(cword_max_t'(s2_a), HALF));
    a_im   = SW'(cplx_im(cword_max_t'(s2_a), HALF));
    p_re   = SW'(signed'(s2_pr));
    p_im   = SW'(signed'(s2_pi));
    sum_re = a_re + p_re;
    sum_im = a_im + p_im;
    dif_re = a_re - p_re;
    dif_im = a_im - p_im;
    if (s2_scale) begin
      sum_re = sum_re >>> 1;
      sum_im = sum_im >>> 1;
      dif_re = dif_re >>> 1;
      dif_im = dif_im >>> 1;
    end
    lim_sr  = limit_half(sum_re);
    lim_si  = limit_half(sum_im);
    lim_dr  = limit_half(dif_re);
    lim_di  = limit_half(dif_im);
    ovf_evt = s2_valid & (lim_sr[HALF] | lim_si[HALF] | lim_dr[HALF] | lim_di[HALF]);
    res_a   = WORD_SZ'(cplx_pack(half_max_t'(lim_sr[HALF-1:0]),
                                 half_max_t'(lim_si[HALF-1:0]), HALF));
    res_b   = WORD_SZ'(cplx_pack(half_max_t'(lim_dr[HALF-1:0]),
                                 half_max_t'(lim_di[HALF-1:0]), HALF));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      o_valid  <= 1'b0;
      o_A      <= '0;
      o_B      <= '0;
      o_ovf    <= 1'b0;
    end else begin
      if (adv) begin
        s1_valid <= i_valid;
        s2_valid <= s1_valid;
        o_valid  <= s2_valid;
        o_A      <= res_a;
        o_B      <= res_b;
      end
      // A new overflow outranks a same-cycle clear.
      if (adv && ovf_evt) o_ovf <= 1'b1;
      else if (i_clr_ovf) o_ovf <= 1'b0;
    end
  end

  // Payload registers need no reset: the valid bits alone decide what is meaningful.
  always_ff @(posedge i_clk) begin
    if (adv) begin
      s1_a     <= i_A;
      s1_b     <= i_B;
      s1_w     <= i_W;
      s1_scale <= i_scale;
      s2_a     <= s1_a;
      s2_scale <= s1_scale;
    end
  end

endmodule
